spi_mem_responder: RTL and testbench



---
 rtl/spi_mem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_responder.sv
// SPI mode-0 serial SRAM target (READ 0x03 / WRITE 0x02) with oversampled pins
// and a backdoor port for preloading and inspecting the byte array.
module spi_mem_responder #(
    parameter int unsigned ADDR_BYTES     = 3,
    parameter int unsigned MEM_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      spi_ce_n,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    input  logic [MEM_ADDR_WIDTH-1:0] bd_addr,
    input  logic                      bd_we,
    input  logic [7:0]                bd_wdata,
    output logic [7:0]                bd_rdata
);
    localparam int unsigned ADDR_BITS = ADDR_BYTES * 8;
    localparam int unsigned CNT_W     = $clog2(ADDR_BITS + 1);
    localparam int unsigned DEPTH     = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

    state_t                    state_q;
    logic [1:0]                sclk_sync_q;
    logic [1:0]                mosi_sync_q;
    logic [1:0]                ce_sync_q;
    logic                      sclk_prev_q;
    logic                      ce_prev_q;
    logic [CNT_W-1:0]          bit_cnt_q;
    logic [7:0]                rx_q;
    logic [7:0]                tx_q;
    logic [7:0]                wr_data_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic                      is_read_q;
    logic                      load_q;
    logic                      wr_pending_q;
    logic                      miso_q;
    logic                      miso_oe_q;
    logic [7:0]                bd_rdata_q;
    logic [7:0]                mem_q [DEPTH];

    logic                      sclk_rise;
    logic                      sclk_fall;
    logic                      ce_high;
    logic                      mosi_s;
    logic [7:0]                rx_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_d;

    always_comb begin
        mosi_s    = mosi_sync_q[1];
        ce_high   = ce_sync_q[1];
        sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
        sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
        rx_d      = {rx_q[6:0], mosi_s};
        addr_d    = {addr_q[MEM_ADDR_WIDTH-2:0], mosi_s};
    end

    // ce_prev resets low so a transfer already in flight at reset is never
    // picked up: only a fresh high-to-low of spi_ce_n starts a command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            ce_sync_q    <= '0;
            sclk_prev_q  <= 1'b0;
            ce_prev_q    <= 1'b0;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            wr_data_q    <= '0;
            addr_q       <= '0;
            is_read_q    <= 1'b0;
            load_q       <= 1'b0;
            wr_pending_q <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], spi_clk};
            mosi_sync_q  <= {mosi_sync_q[0], spi_mosi};
            ce_sync_q    <= {ce_sync_q[0], spi_ce_n};
            sclk_prev_q  <= sclk_sync_q[1];
            ce_prev_q    <= ce_sync_q[1];
            load_q       <= 1'b0;
            wr_pending_q <= 1'b0;
            if (load_q) begin
                tx_q <= mem_q[addr_q];
            end
            if (wr_pending_q) begin
                addr_q <= addr_q + 1'b1;
            end

            if (ce_high) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (ce_prev_q) begin
                            state_q   <= S_CMD;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            rx_q <= rx_d;
                            if (bit_cnt_q == CNT_W'(7)) begin
                                bit_cnt_q <= '0;
                                if (rx_d == 8'h03) begin
                                    is_read_q <= 1'b1;
                                    state_q   <= S_ADDR;
                                end else if (rx_d == 8'h02) begin
                                    is_read_q <= 1'b0;
                                    state_q   <= S_ADDR;
                                end else begin
                                    state_q <= S_IGNORE;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            addr_q <= addr_d;
                            if (bit_cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                                bit_cnt_q <= '0;
                                if (is_read_q) begin
                                    state_q   <= S_READ;
                                    load_q    <= 1'b1;
                                    miso_oe_q <= 1'b1;
                                end else begin
                                    state_q <= S_WRITE;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        miso_oe_q <= 1'b1;
                        if (sclk_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                            if (bit_cnt_q == CNT_W'(7)) begin
                                bit_cnt_q <= '0;
                                addr_q    <= addr_q + 1'b1;
                                load_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (sclk_rise) begin
                            rx_q <= rx_d;
                            if (bit_cnt_q == CNT_W'(7)) begin
                                bit_cnt_q    <= '0;
                                wr_data_q    <= rx_d;
                                wr_pending_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        miso_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Backdoor write is issued last so it overrides an SPI byte to the same address.
    always_ff @(posedge clk) begin
        if (wr_pending_q) begin
            mem_q[addr_q] <= wr_data_q;
        end
        if (bd_we) begin
            mem_q[bd_addr] <= bd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bd_rdata_q <= '0;
        end else begin
            bd_rdata_q <= mem_q[bd_addr];
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign bd_rdata    = bd_rdata_q;
endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: an SPI initiator driving directed and random
// transactions, checked against a byte-array model of the memory.
module tb_spi_mem_responder;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_ce_n = 1'b1;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] bd_addr = '0;
    logic       bd_we = 1'b0;
    logic [7:0] bd_wdata = '0;
    logic [7:0] bd_rdata;

    int         n_tests = 0;
    int         n_fail = 0;
    int         oe_cycles = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] tx_buf [8];

    spi_mem_responder #(
        .ADDR_BYTES(3),
        .MEM_ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .spi_ce_n(spi_ce_n),
        .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .bd_addr(bd_addr),
        .bd_we(bd_we),
        .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (spi_miso_oe === 1'b1) oe_cycles <= oe_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[3'(7 - i)];
            wait_clks(HALF);
            rx = {rx[6:0], spi_miso};
            spi_clk = 1'b1;
            wait_clks(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_start();
        spi_ce_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic spi_stop();
        wait_clks(HALF);
        spi_ce_n = 1'b1;
        wait_clks(8);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] d;
        spi_bits(cmd, 8, d);
        spi_bits(a[23:16], 8, d);
        spi_bits(a[15:8], 8, d);
        spi_bits(a[7:0], 8, d);
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        wait_clks(1);
        bd_we    = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
        bd_addr = a;
        wait_clks(1);
        d = bd_rdata;
    endtask

    task automatic do_write(input logic [23:0] a, input int n);
        logic [7:0] d;
        logic [7:0] idx;
        spi_start();
        send_hdr(8'h02, a);
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, d);
            idx = a[7:0] + 8'(i);
            ref_mem[idx] = tx_buf[i];
        end
        spi_stop();
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input string tag);
        logic [7:0] d;
        logic [7:0] idx;
        int         o0;
        o0 = oe_cycles;
        spi_start();
        send_hdr(8'h03, a);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'($urandom), 8, d);
            idx = a[7:0] + 8'(i);
            check(tag, d, ref_mem[idx]);
        end
        spi_stop();
        check("rd_oe_active", 32'(oe_cycles > o0), 1);
    endtask

    task automatic do_junk(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] d;
        int         o0;
        o0 = oe_cycles;
        spi_start();
        send_hdr(cmd, a);
        spi_bits(8'($urandom), 8, d);
        spi_bits(8'($urandom), 8, d);
        spi_stop();
        check("junk_oe_quiet", oe_cycles - o0, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [7:0]  c;
        logic [23:0] a;
        int          n;
        int          r;
        int          o0;

        wait_clks(3);
        check("rst_miso", spi_miso, 0);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_bd_rdata", bd_rdata, 0);
        rst = 1'b0;
        wait_clks(2);

        for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));

        // write then read back over SPI and backdoor
        tx_buf[0] = 8'hA5;
        tx_buf[1] = 8'h3C;
        do_write(24'h000010, 2);
        bd_read(8'h10, d);
        check("wr_bd_10", d, 8'hA5);
        bd_read(8'h11, d);
        check("wr_bd_11", d, 8'h3C);
        do_read(24'h000010, 2, "rd_after_wr");

        // sequential read wraps; upper address byte ignored
        bd_write(8'hFF, 8'h11);
        bd_write(8'h00, 8'h22);
        do_read(24'hAB00FF, 2, "rd_wrap");

        do_junk(8'h9F, 24'($urandom));

        // aborted write leaves the partial byte unwritten
        spi_start();
        send_hdr(8'h02, 24'h000020);
        spi_bits(~ref_mem[8'h20], 5, d);
        spi_stop();
        bd_read(8'h20, d);
        check("abort_mem", d, ref_mem[8'h20]);
        do_read(24'h000020, 1, "after_abort");

        // reset in the middle of a read
        bd_write(8'h40, 8'hFF);
        bd_write(8'h41, 8'hA5);
        spi_start();
        send_hdr(8'h03, 24'h000040);
        spi_bits(8'h00, 2, d);
        check("rmr_first_bits", d, 8'h03);
        spi_mosi = 1'b0;
        wait_clks(4);
        check("rmr_oe_before", spi_miso_oe, 1);
        check("rmr_miso_before", spi_miso, 1);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check("rmr_oe_after", spi_miso_oe, 0);
        check("rmr_miso_after", spi_miso, 0);
        o0 = oe_cycles;
        spi_clk = 1'b1;
        wait_clks(HALF);
        spi_clk = 1'b0;
        spi_bits(8'h00, 5, d);
        send_hdr(8'h02, 24'h000041);
        spi_bits(8'h00, 8, d);
        spi_stop();
        check("rmr_oe_quiet", oe_cycles - o0, 0);
        bd_read(8'h41, d);
        check("rmr_mem_41", d, ref_mem[8'h41]);
        do_read(24'h000040, 2, "after_rst");

        // backdoor and SPI write collide on the same address
        spi_start();
        send_hdr(8'h02, 24'h000030);
        spi_bits(8'h99, 7, d);
        spi_mosi = 1'b1;
        wait_clks(HALF);
        bd_addr  = 8'h30;
        bd_wdata = 8'h77;
        bd_we    = 1'b1;
        spi_clk  = 1'b1;
        wait_clks(HALF);
        spi_clk  = 1'b0;
        wait_clks(2);
        bd_we    = 1'b0;
        ref_mem[8'h30] = 8'h77;
        spi_stop();
        bd_read(8'h30, d);
        check("collide_mem_30", d, 8'h77);

        // backdoor read returns the pre-write value
        c = ~ref_mem[8'h50];
        bd_addr  = 8'h50;
        bd_wdata = c;
        bd_we    = 1'b1;
        wait_clks(1);
        check("bd_prewrite", bd_rdata, ref_mem[8'h50]);
        bd_we    = 1'b0;
        ref_mem[8'h50] = c;
        wait_clks(1);
        check("bd_postwrite", bd_rdata, c);

        for (int k = 0; k < 24; k++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a[7:0] = 8'hFE;
            if (r == 0) begin
                c = 8'($urandom);
                if (c == 8'h02 || c == 8'h03) c = 8'hFF;
                do_junk(c, a);
            end else if (r < 5) begin
                for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
                do_write(a, n);
            end else begin
                do_read(a, n, "rand_rd");
            end
        end

        for (int i = 0; i < 256; i++) begin
            bd_read(8'(i), d);
            check("sweep_mem", d, ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
